timer_dev: RTL and testbench
============================

TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset; synchronous, active-low; sampled on rising edge of clk.
REQ-003 Addr  input  2  word select within device (PrAddr[3:2]); 00 CTRL, 01 PRESET, 10 COUNT, 11 reserved.
REQ-004 WE  input  1  write strobe from bridge (PrWe qualified by device hit); one cycle per write.
REQ-005 DIn  input  32  write data.
REQ-006 DOut  output  32  read data for Addr, combinational from registers.
REQ-007 IRQ  output  1  interrupt request to CPU interrupt input (IntReq path); active-high.

Function
REQ-008 CTRL register: bit0 EN (count enable), bits2:1 MODE, bit3 IM (interrupt mask, 1 = enabled); bits31:4 read 0 and ignore writes.
REQ-009 MODE 00 = one-shot; 01 = auto-reload; 10 and 11 behave as 00.
REQ-010 PRESET: 32-bit read/write; a write never alters COUNT directly, it takes effect at the next LOAD.
REQ-011 COUNT: 32-bit read-only; writes to Addr 10 ignored; Addr 11 reads 0, writes ignored.
REQ-012 A write with WE=1 updates the addressed register at the same rising edge; DOut reflects it in the following cycle.
REQ-013 FSM states: IDLE, LOAD, CNT, INT; reset state IDLE.
REQ-014 IDLE: EN=1 -> LOAD; else stay; COUNT holds.
REQ-015 LOAD: COUNT <= PRESET; -> CNT.
REQ-016 CNT: EN=0 -> IDLE (COUNT holds); COUNT > 1 -> COUNT-1, stay; COUNT <= 1 -> COUNT <= 0, -> INT, set irq_flag at the same edge.
REQ-017 INT, MODE 00: clear EN, -> IDLE next edge; irq_flag held.
REQ-018 INT, MODE 01: clear irq_flag, -> LOAD next edge; EN kept; IRQ high exactly one cycle per expiry.
REQ-019 Any CTRL write clears irq_flag; a CTRL write with EN=0 in any state forces IDLE at the next edge.
REQ-020 Same-edge conflict in INT, MODE 00: CPU CTRL write wins over the FSM clearing EN.
REQ-021 IRQ = irq_flag AND IM; IM=0 masks output but does not clear irq_flag.
REQ-022 Latency: EN written at edge E0; LOAD at E1; COUNT=PRESET after E2; first decrement at E3; PRESET=N (N>=1) enters INT at edge E2+N.
REQ-023 PRESET=0 behaves as PRESET=1: INT one edge after LOAD.
REQ-024 No wrap-around: COUNT never decrements below 0.

Reset
REQ-025 rst=0 at a rising edge: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state IDLE; IRQ=0, DOut for any Addr=0 in the next cycle.
REQ-026 Reset mid-count or in INT overrides all writes and FSM actions at that edge.
REQ-027 Reset is level: held low keeps all outputs at reset values every cycle.

Verification
REQ-028 Write PRESET=3, then CTRL=0x9 (EN, IM, MODE 00) at E0 -> COUNT 3,2,1,0 after E2..E5; IRQ=1 from E5, EN reads 0 after E6, IRQ held until next CTRL write, then 0.
REQ-029 PRESET=2, CTRL=0xB (MODE 01, IM) -> IRQ one-cycle pulse every 4 cycles (LOAD, CNT, CNT, INT); COUNT repeats 2,1,0.
REQ-030 PRESET=5, CTRL=0x1 (IM=0) -> expiry sets flag, IRQ stays 0; then write CTRL=0x8 -> IRQ stays 0 (flag cleared by write).
REQ-031 PRESET=10 counting; at COUNT=6 write CTRL=0x0 -> IDLE next edge, COUNT holds 5 or 6 per edge, no IRQ; rewrite EN -> COUNT reloaded to 10.
REQ-032 PRESET=100 counting; write PRESET=7 mid-count -> current run continues from old value; MODE 01 reload uses 7.
REQ-033 Assert rst=0 while in INT with IRQ=1 -> next cycle IRQ=0, all reads 0, Addr 11 and COUNT writes never change DOut.

Source files
------------

// File: rtl/timer_dev_if.sv
// Register bus between the address-decode bridge and the timer device.
// The bridge drives the address, strobe and data; the timer returns read data and its interrupt.
interface timer_dev_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  modport master (output Addr, WE, DIn, input DOut, IRQ);
  modport slave  (input Addr, WE, DIn, output DOut, IRQ);
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped down-counter timer with CTRL/PRESET/COUNT registers.
// Supports one-shot and auto-reload modes and raises a maskable interrupt when the count expires.
module timer_dev (
  input  logic       clk,
  input  logic       rst,
  timer_dev_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t      state, next_state;
  logic        ctrl_en, ctrl_im;
  logic [1:0]  ctrl_mode;
  logic [31:0] preset, count;
  logic        irq_flag;
  logic        ctrl_wr, preset_wr, auto_reload;
  logic        do_load, do_dec, do_expire, do_clr_irq, do_clr_en;

  assign ctrl_wr     = bus.WE && (bus.Addr == 2'b00);
  assign preset_wr   = bus.WE && (bus.Addr == 2'b01);
  assign auto_reload = (ctrl_mode == 2'b01);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // A CTRL write that clears EN overrides whatever the FSM would otherwise do next.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (ctrl_en) next_state = S_LOAD;
      S_LOAD:  next_state = S_CNT;
      S_CNT: begin
        if (!ctrl_en)             next_state = S_IDLE;
        else if (count <= 32'd1)  next_state = S_INT;
      end
      S_INT:   next_state = auto_reload ? S_LOAD : S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (ctrl_wr && !bus.DIn[0]) next_state = S_IDLE;
  end

  always_comb begin
    do_load    = 1'b0;
    do_dec     = 1'b0;
    do_expire  = 1'b0;
    do_clr_irq = 1'b0;
    do_clr_en  = 1'b0;
    case (state)
      S_LOAD: do_load = 1'b1;
      S_CNT: begin
        if (ctrl_en) begin
          if (count > 32'd1) do_dec    = 1'b1;
          else               do_expire = 1'b1;
        end
      end
      S_INT: begin
        if (auto_reload) do_clr_irq = 1'b1;
        else             do_clr_en  = 1'b1;
      end
      default: ;
    endcase
  end

  // CPU writes take priority over FSM-driven updates of EN and the interrupt flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'b00;
      ctrl_im   <= 1'b0;
      preset    <= '0;
      count     <= '0;
      irq_flag  <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl_en   <= bus.DIn[0];
        ctrl_mode <= bus.DIn[2:1];
        ctrl_im   <= bus.DIn[3];
      end else if (do_clr_en) begin
        ctrl_en <= 1'b0;
      end

      if (preset_wr) preset <= bus.DIn;

      if (do_load)        count <= preset;
      else if (do_dec)    count <= count - 32'd1;
      else if (do_expire) count <= '0;

      if (ctrl_wr || do_clr_irq) irq_flag <= 1'b0;
      else if (do_expire)        irq_flag <= 1'b1;
    end
  end

  always_comb begin
    case (bus.Addr)
      2'b00:   bus.DOut = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
      2'b01:   bus.DOut = preset;
      2'b10:   bus.DOut = count;
      default: bus.DOut = '0;
    endcase
  end

  assign bus.IRQ = irq_flag & ctrl_im;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: register access, one-shot, auto-reload, masking, stop/restart and reset.
module tb_timer_dev;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  timer_dev_if bus ();

  timer_dev dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Each helper leaves the bench 1ns after a rising edge, so reads never race the clock.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = a;
    bus.WE   = 1'b1;
    bus.DIn  = d;
    tick();
    bus.WE   = 1'b0;
    bus.DIn  = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.Addr = a;
    #1;
    d = bus.DOut;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0; bus.WE = 1'b0; bus.Addr = 2'b00; bus.DIn = '0;
    tick(); tick();
    checks++; if (bus.IRQ !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b, expected 0", bus.IRQ); end
    for (int a = 0; a < 4; a++) begin
      logic [1:0] aa;
      aa = a[1:0];
      rd(aa, d);
      checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL reset_dout addr %0d: got %h, expected 0", a, d); end
    end
    rst = 1'b1;
  endtask

  task automatic test_regs();
    logic [31:0] d;
    wr(2'b01, 32'hDEADBEEF);
    rd(2'b01, d);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL preset_rw: got %h, expected deadbeef", d); end
    wr(2'b00, 32'hFFFFFFFE);
    rd(2'b00, d);
    checks++; if (d !== 32'h0000000E) begin errors++; $display("[TB] FAIL ctrl_upper_bits: got %h, expected 0000000e", d); end
    wr(2'b10, 32'h12345678);
    rd(2'b10, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL count_readonly: got %h, expected 0", d); end
    wr(2'b11, 32'hFFFFFFFF);
    rd(2'b11, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL reserved_read: got %h, expected 0", d); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    wr(2'b01, 32'd3);
    wr(2'b00, 32'h9);
    tick();
    rd(2'b10, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL oneshot_load_latency: got %h, expected 0", d); end
    for (int i = 0; i < 4; i++) begin
      tick();
      rd(2'b10, d);
      checks++; if (d !== 32'(3 - i)) begin errors++; $display("[TB] FAIL oneshot_count step %0d: got %0d, expected %0d", i, d, 3 - i); end
      checks++; if (bus.IRQ !== (i == 3)) begin errors++; $display("[TB] FAIL oneshot_irq step %0d: got %b, expected %b", i, bus.IRQ, (i == 3)); end
    end
    tick();
    rd(2'b00, d);
    checks++; if (d !== 32'h8) begin errors++; $display("[TB] FAIL oneshot_en_cleared: got %h, expected 8", d); end
    tick();
    checks++; if (bus.IRQ !== 1'b1) begin errors++; $display("[TB] FAIL oneshot_irq_held: got %b, expected 1", bus.IRQ); end
    wr(2'b00, 32'h8);
    checks++; if (bus.IRQ !== 1'b0) begin errors++; $display("[TB] FAIL oneshot_irq_cleared: got %b, expected 0", bus.IRQ); end
  endtask

  task automatic test_auto_reload();
    logic [31:0] d;
    logic [31:0] exp_cnt;
    wr(2'b01, 32'd2);
    wr(2'b00, 32'hB);
    tick();
    for (int i = 0; i < 9; i++) begin
      tick();
      case (i % 4)
        0:       exp_cnt = 32'd2;
        1:       exp_cnt = 32'd1;
        default: exp_cnt = 32'd0;
      endcase
      rd(2'b10, d);
      checks++; if (d !== exp_cnt) begin errors++; $display("[TB] FAIL reload_count cycle %0d: got %0d, expected %0d", i, d, exp_cnt); end
      checks++; if (bus.IRQ !== ((i % 4) == 2)) begin errors++; $display("[TB] FAIL reload_irq cycle %0d: got %b, expected %b", i, bus.IRQ, ((i % 4) == 2)); end
    end
    wr(2'b00, 32'h0);
  endtask

  task automatic test_masked();
    logic [31:0] d;
    wr(2'b01, 32'd5);
    wr(2'b00, 32'h1);
    tick(); tick();
    rd(2'b10, d);
    checks++; if (d !== 32'd5) begin errors++; $display("[TB] FAIL masked_load: got %0d, expected 5", d); end
    repeat (5) tick();
    rd(2'b10, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL masked_expired: got %0d, expected 0", d); end
    checks++; if (bus.IRQ !== 1'b0) begin errors++; $display("[TB] FAIL masked_irq: got %b, expected 0", bus.IRQ); end
    tick();
    rd(2'b00, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL masked_en_cleared: got %h, expected 0", d); end
    wr(2'b00, 32'h8);
    checks++; if (bus.IRQ !== 1'b0) begin errors++; $display("[TB] FAIL masked_unmask_after_clear: got %b, expected 0", bus.IRQ); end
  endtask

  task automatic test_stop_restart();
    logic [31:0] d;
    wr(2'b01, 32'd10);
    wr(2'b00, 32'h9);
    repeat (6) tick();
    rd(2'b10, d);
    checks++; if (d !== 32'd6) begin errors++; $display("[TB] FAIL stop_precount: got %0d, expected 6", d); end
    wr(2'b00, 32'h0);
    for (int i = 0; i < 3; i++) begin
      rd(2'b10, d);
      checks++; if (d !== 32'd5) begin errors++; $display("[TB] FAIL stop_hold cycle %0d: got %0d, expected 5", i, d); end
      checks++; if (bus.IRQ !== 1'b0) begin errors++; $display("[TB] FAIL stop_irq cycle %0d: got %b, expected 0", i, bus.IRQ); end
      tick();
    end
    wr(2'b00, 32'h9);
    tick(); tick();
    rd(2'b10, d);
    checks++; if (d !== 32'd10) begin errors++; $display("[TB] FAIL restart_reload: got %0d, expected 10", d); end
    wr(2'b00, 32'h0);
  endtask

  task automatic test_preset_midrun();
    logic [31:0] d;
    wr(2'b01, 32'd100);
    wr(2'b00, 32'hB);
    tick(); tick();
    rd(2'b10, d);
    checks++; if (d !== 32'd100) begin errors++; $display("[TB] FAIL midrun_load: got %0d, expected 100", d); end
    tick();
    wr(2'b01, 32'd7);
    rd(2'b10, d);
    checks++; if (d !== 32'd98) begin errors++; $display("[TB] FAIL midrun_continue: got %0d, expected 98", d); end
    rd(2'b01, d);
    checks++; if (d !== 32'd7) begin errors++; $display("[TB] FAIL midrun_preset: got %0d, expected 7", d); end
    repeat (98) tick();
    rd(2'b10, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL midrun_expire_count: got %0d, expected 0", d); end
    checks++; if (bus.IRQ !== 1'b1) begin errors++; $display("[TB] FAIL midrun_expire_irq: got %b, expected 1", bus.IRQ); end
    tick();
    checks++; if (bus.IRQ !== 1'b0) begin errors++; $display("[TB] FAIL midrun_pulse_end: got %b, expected 0", bus.IRQ); end
    tick();
    rd(2'b10, d);
    checks++; if (d !== 32'd7) begin errors++; $display("[TB] FAIL midrun_new_preset: got %0d, expected 7", d); end
  endtask

  task automatic test_reset_in_int();
    logic [31:0] d;
    repeat (7) tick();
    checks++; if (bus.IRQ !== 1'b1) begin errors++; $display("[TB] FAIL int_before_reset: got %b, expected 1", bus.IRQ); end
    rst = 1'b0;
    wr(2'b10, 32'h55);
    checks++; if (bus.IRQ !== 1'b0) begin errors++; $display("[TB] FAIL int_reset_irq: got %b, expected 0", bus.IRQ); end
    for (int a = 0; a < 4; a++) begin
      logic [1:0] aa;
      aa = a[1:0];
      rd(aa, d);
      checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL int_reset_dout addr %0d: got %h, expected 0", a, d); end
    end
    wr(2'b00, 32'hF);
    rd(2'b00, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL reset_held_ctrl: got %h, expected 0", d); end
    rst = 1'b1;
    wr(2'b11, 32'hFFFF);
    rd(2'b11, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL post_reset_reserved: got %h, expected 0", d); end
    wr(2'b10, 32'h1234);
    rd(2'b10, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL post_reset_count_write: got %h, expected 0", d); end
  endtask

  task automatic test_preset_zero();
    logic [31:0] d;
    wr(2'b01, 32'd0);
    wr(2'b00, 32'hD);
    tick(); tick();
    rd(2'b10, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL zero_load: got %0d, expected 0", d); end
    checks++; if (bus.IRQ !== 1'b0) begin errors++; $display("[TB] FAIL zero_irq_early: got %b, expected 0", bus.IRQ); end
    tick();
    checks++; if (bus.IRQ !== 1'b1) begin errors++; $display("[TB] FAIL zero_irq: got %b, expected 1", bus.IRQ); end
    tick();
    rd(2'b00, d);
    checks++; if (d !== 32'hC) begin errors++; $display("[TB] FAIL mode10_oneshot: got %h, expected c", d); end
    checks++; if (bus.IRQ !== 1'b1) begin errors++; $display("[TB] FAIL mode10_irq_held: got %b, expected 1", bus.IRQ); end
    wr(2'b00, 32'h0);
    checks++; if (bus.IRQ !== 1'b0) begin errors++; $display("[TB] FAIL zero_irq_clear: got %b, expected 0", bus.IRQ); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_oneshot();
    test_auto_reload();
    test_masked();
    test_stop_restart();
    test_preset_midrun();
    test_reset_in_int();
    test_preset_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
